inst_fetch_buffer: RTL

- 3-wide circular FIFO between the fetch stage and the dispatch stage.
- Absorbs fetch bundles, then presents the three oldest buffered instructions to dispatch as IF_ID_PACKET [2:0]. Slot [2] is always the oldest.
- Retires exactly the number of instructions dispatch reports as accepted.
- Drops instructions younger than a predicted-taken branch at enqueue; flushes on squash.

---
 rtl/inst_fetch_buffer_pkg.sv | 19 +
 rtl/inst_fetch_buffer_enq_filter.sv | 26 ++
 rtl/inst_fetch_buffer.sv | 92 +++++++++
 3 files changed

// File: rtl/inst_fetch_buffer_pkg.sv
// Shared types and constants for the 3-wide instruction fetch buffer.
package inst_fetch_buffer_pkg;

  localparam int IBUF_DEPTH_DEF = 8;
  localparam int FETCH_WIDTH    = 3;

  typedef struct packed {
    logic        valid;
    logic [31:0] inst;
    logic [31:0] PC;
    logic [31:0] NPC;
    logic        bp_pred_taken;
  } IF_ID_PACKET;

  function automatic logic [1:0] min_2b(input logic [1:0] a, input logic [1:0] b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/inst_fetch_buffer_enq_filter.sv
// Compacts a fetch bundle oldest-first and truncates it after the first
// predicted-taken packet; invalid slots leave no hole in the output.
module ibuf_enq_filter
  import inst_fetch_buffer_pkg::*;
(
  input  IF_ID_PACKET [2:0] fetch_pkts,
  output IF_ID_PACKET [2:0] enq_pkts,
  output logic [1:0]        n_enq
);

  logic stop;

  always_comb begin
    enq_pkts = '0;
    n_enq    = 2'd0;
    stop     = 1'b0;
    for (int i = 2; i >= 0; i--) begin
      if (!stop && fetch_pkts[i].valid) begin
        enq_pkts[2'd2 - n_enq] = fetch_pkts[i];
        n_enq                  = n_enq + 2'd1;
        stop                   = fetch_pkts[i].bp_pred_taken;
      end
    end
  end

endmodule

// File: rtl/inst_fetch_buffer.sv
// Circular buffer between fetch and dispatch; presents the three oldest
// entries with slot [2] the oldest and retires what dispatch accepts.
module inst_fetch_buffer
  import inst_fetch_buffer_pkg::*;
#(
  parameter  int IBUF_DEPTH = IBUF_DEPTH_DEF,
  localparam int IBUF_PTR_W = $clog2(IBUF_DEPTH),
  localparam int IBUF_CNT_W = $clog2(IBUF_DEPTH) + 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  squash,
  input  IF_ID_PACKET [2:0]     fetch_pkts,
  input  logic [1:0]            dispatch_num_taken,
  output IF_ID_PACKET [2:0]     dispatch_if_pkts,
  output logic                  ibuf_fetch_stall,
  output logic [IBUF_CNT_W-1:0] ibuf_count
);

  IF_ID_PACKET                  entries_q [IBUF_DEPTH];
  IF_ID_PACKET                  entries_d [IBUF_DEPTH];
  logic        [IBUF_PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic        [IBUF_CNT_W-1:0] count_q, count_d;

  IF_ID_PACKET [2:0] enq_pkts;
  logic        [1:0] n_enq, n_enq_eff, n_deq, deq_cap;

  ibuf_enq_filter u_enq_filter (
    .fetch_pkts (fetch_pkts),
    .enq_pkts   (enq_pkts),
    .n_enq      (n_enq)
  );

  // Stall looks only at registered occupancy, so a same-cycle dequeue
  // cannot open room for this cycle's bundle.
  assign ibuf_fetch_stall = (count_q > IBUF_CNT_W'(IBUF_DEPTH - 3));
  assign ibuf_count       = count_q;

  assign deq_cap   = (count_q >= IBUF_CNT_W'(3)) ? 2'd3 : count_q[1:0];
  assign n_deq     = min_2b(dispatch_num_taken, deq_cap);
  assign n_enq_eff = ibuf_fetch_stall ? 2'd0 : n_enq;

  always_comb begin
    for (int k = 0; k < 3; k++) begin
      dispatch_if_pkts[2-k] = entries_q[head_q + IBUF_PTR_W'(k)];
      if (IBUF_CNT_W'(k) >= count_q) dispatch_if_pkts[2-k].valid = 1'b0;
    end
  end

  always_comb begin
    entries_d = entries_q;
    head_d    = head_q;
    tail_d    = tail_q;
    count_d   = count_q;
    if (squash) begin
      for (int i = 0; i < IBUF_DEPTH; i++) entries_d[i].valid = 1'b0;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      // Write slots never alias live entries: enqueue needs three free slots.
      for (int k = 0; k < 3; k++) begin
        if (2'(k) < n_deq) entries_d[head_q + IBUF_PTR_W'(k)].valid = 1'b0;
      end
      for (int k = 0; k < 3; k++) begin
        if (2'(k) < n_enq_eff) entries_d[tail_q + IBUF_PTR_W'(k)] = enq_pkts[2-k];
      end
      head_d  = head_q + IBUF_PTR_W'(n_deq);
      tail_d  = tail_q + IBUF_PTR_W'(n_enq_eff);
      count_d = count_q + IBUF_CNT_W'(n_enq_eff) - IBUF_CNT_W'(n_deq);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < IBUF_DEPTH; i++) entries_q[i] <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      entries_q <= entries_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
    end
  end

  a_deq_legal : assert property (@(posedge clock) disable iff (reset || squash)
    dispatch_num_taken <= deq_cap)
    else $error("dispatch_num_taken exceeds buffered instructions");

endmodule
